// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B controller: one full-subtractor cell and a borrow flop walk
// the operands LSB first, with a start/busy/done handshake around the datapath.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Returns {borrow, difference} of x - y.
  function automatic logic [1:0] half_sub(input logic x, input logic y);
    return {~x & y, x ^ y};
  endfunction

  // Two half-subtractor stages with their borrows ORed: {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
    logic [1:0] h1;
    logic [1:0] h2;
    h1 = half_sub(x, y);
    h2 = half_sub(h1[0], bin);
    return {h1[1] | h2[1], h2[0]};
  endfunction

  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_r;
  logic             bor_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;

  logic [1:0]       cell_s;
  logic [WIDTH-1:0] res_nxt_s;
  logic             last_s;

  // Bit cell on the current LSBs and the result word with the new bit at the MSB.
  always_comb begin
    cell_s    = full_sub(a_sr_r[0], b_sr_r[0], bor_r);
    res_nxt_s = (res_r >> 1) | (WIDTH'(cell_s[0]) << (WIDTH - 1));
    last_s    = (cnt_r == CNT_LAST);
  end

  // Control FSM, operand shifters, borrow flop and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      a_sr_r   <= '0;
      b_sr_r   <= '0;
      res_r    <= '0;
      bor_r    <= 1'b0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_sr_r  <= a_in;
            b_sr_r  <= b_in;
            bor_r   <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sr_r <= a_sr_r >> 1;
          b_sr_r <= b_sr_r >> 1;
          res_r  <= res_nxt_s;
          bor_r  <= cell_s[1];
          cnt_r  <= cnt_r + CW'(1);
          if (last_s) begin
            diff_r   <= res_nxt_s;
            borrow_r <= cell_s[1];
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= ST_DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign diff_out   = diff_r;
  assign borrow_out = borrow_r;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: WIDTH=8 and WIDTH=1 instances, random
// and directed operands, results predicted by plain unsigned arithmetic.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0;
  logic       start1 = 1'b0;
  logic [7:0] a8 = 8'd0;
  logic [7:0] b8 = 8'd0;
  logic [0:0] a1 = 1'b0;
  logic [0:0] b1 = 1'b0;
  logic       busy8, done8, borrow8;
  logic       busy1, done1, borrow1;
  logic [7:0] diff8;
  logic [0:0] diff1;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: edge counter, accepting-edge index, expected results.
  int cyc = 0;
  int c0_8 = -1000;
  int c0_1 = -1000;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [8:0] held8 = 9'd0;
  logic [1:0] held1 = 2'd0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8),
    .busy(busy8), .done(done8), .diff_out(diff8), .borrow_out(borrow8)
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1),
    .busy(busy1), .done(done1), .diff_out(diff1), .borrow_out(borrow1)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: a request is taken when the previous operation (W+2 cycles) is over.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q8.delete();
      q1.delete();
      c0_8 = -1000;
      c0_1 = -1000;
    end else begin
      cyc++;
      if (start8 && cyc >= c0_8 + 10) begin
        c0_8 = cyc;
        q8.push_back({int'(a8) < int'(b8), 8'((int'(a8) - int'(b8) + 256) % 256)});
      end
      if (start1 && cyc >= c0_1 + 3) begin
        c0_1 = cyc;
        q1.push_back({int'(a1) < int'(b1), 1'((int'(a1) - int'(b1) + 2) % 2)});
      end
    end
  end

  // Monitor: checks handshake timing each cycle and pops results on done.
  always @(negedge clk) begin
    if (!rst_n) begin
      held8 = 9'd0;
      held1 = 2'd0;
    end else begin
      chk("busy8", busy8, cyc >= c0_8 && cyc < c0_8 + 8);
      chk("done8", done8, cyc == c0_8 + 8);
      if (done8) begin
        if (q8.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL spurious_done8 at %0t", $time);
        end else begin
          held8 = q8.pop_front();
        end
      end
      chk("diff8", diff8, held8[7:0]);
      chk("borrow8", borrow8, held8[8]);
      chk("busy1", busy1, cyc >= c0_1 && cyc < c0_1 + 1);
      chk("done1", done1, cyc == c0_1 + 1);
      if (done1) begin
        if (q1.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL spurious_done1 at %0t", $time);
        end else begin
          held1 = q1.pop_front();
        end
      end
      chk("diff1", diff1, held1[0]);
      chk("borrow1", borrow1, held1[1]);
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (q8.size() == 0 && q1.size() == 0 && cyc >= c0_8 + 9 && cyc >= c0_1 + 2) return;
      @(negedge clk);
    end
    n_chk++; n_fail++;
    $display("FAIL idle_timeout at %0t", $time);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    wait_idle();
  endtask

  task automatic op1(input logic a, input logic b);
    @(negedge clk);
    a1 = a; b1 = b; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom);
    wait_idle();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_diff", diff8, 8'h00);
    chk("rst_borrow", borrow8, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    op8(8'd100, 8'd37);
    op8(8'd5, 8'd9);
    op8(8'h00, 8'hFF);
    op8(8'h00, 8'h00);
    op8(8'hFF, 8'hFF);

    // start held high across two operations; second operands after first accept
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20;
    repeat (12) @(negedge clk);
    start8 = 1'b0;
    wait_idle();

    // operands and start toggled during RUN and DONE
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h5A; start8 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    start8 = 1'b0;
    wait_idle();

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy8, 1'b0);
    chk("arst_done", done8, 1'b0);
    chk("arst_diff", diff8, 8'h00);
    chk("arst_borrow", borrow8, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    op8(8'h42, 8'h17);

    for (int i = 0; i < 25; i++) begin
      op8(8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    op1(1'b0, 1'b1);
    op1(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) op1(1'($urandom), 1'($urandom));

    repeat (3) @(negedge clk);
    chk("q8_empty", q8.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
